exec_core: RTL

Multi-cycle fetch/execute core. It fetches 32-bit instructions from a synchronous instruction memory and executes the existing arithmetic/logical ISA on a 32-entry general-purpose register file. It registers the result and the condition flags on a clock edge and advances the program counter. It replaces the single-cycle combinational ALU and register file, and sits between the instruction BRAM and the future load/store and branch stages.

---
 rtl/exec_core_pkg.sv | 55 +++++
 rtl/exec_core_alu.sv | 74 +++++++
 rtl/exec_core.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/exec_core_pkg.sv
// Shared definitions for the exec_core fetch/execute core: opcodes, IR field positions, FSM states, flags.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional feature macro: EXEC_CORE_MUL_EN (multiplier, SGPR, MUL and MOVSGPR).
package exec_core_pkg;

    localparam logic [4:0] OP_MOVSGPR = 5'b00000;
    localparam logic [4:0] OP_MOV     = 5'b00001;
    localparam logic [4:0] OP_ADD     = 5'b00010;
    localparam logic [4:0] OP_SUB     = 5'b00011;
    localparam logic [4:0] OP_MUL     = 5'b00100;
    localparam logic [4:0] OP_OR      = 5'b00101;
    localparam logic [4:0] OP_AND     = 5'b00110;
    localparam logic [4:0] OP_XOR     = 5'b00111;
    localparam logic [4:0] OP_XNOR    = 5'b01000;
    localparam logic [4:0] OP_NAND    = 5'b01001;
    localparam logic [4:0] OP_NOR     = 5'b01010;
    localparam logic [4:0] OP_NOT     = 5'b01011;
    localparam logic [4:0] OP_HALT    = 5'b11111;

    localparam int IR_OPER_HI  = 31;
    localparam int IR_OPER_LO  = 27;
    localparam int IR_RDST_HI  = 26;
    localparam int IR_RDST_LO  = 22;
    localparam int IR_RSRC1_HI = 21;
    localparam int IR_RSRC1_LO = 17;
    localparam int IR_IMM_BIT  = 16;
    localparam int IR_RSRC2_HI = 15;
    localparam int IR_RSRC2_LO = 11;
    localparam int IR_ISRC_HI  = 15;
    localparam int IR_ISRC_LO  = 0;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;

    typedef struct packed {
        logic sign;
        logic zero;
        logic carry;
        logic overflow;
    } flags_t;

    // Opcodes that write a GPR and the flags. HALT is handled separately by the FSM.
    function automatic logic op_writes(input logic [4:0] op);
        logic ok;
        case (op)
            OP_MOV, OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR,
            OP_XNOR, OP_NAND, OP_NOR, OP_NOT: ok = 1'b1;
`ifdef EXEC_CORE_MUL_EN
            OP_MUL, OP_MOVSGPR: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/exec_core_alu.sv
// Combinational ALU for exec_core: result, product high half and next flags from opcode and operands.
// Latency: 0 cycles (purely combinational). Backpressure: none.
// Ports: op, a (rsrc1 value), b (selected second operand), imm_mode -> res, res_hi, flags. Macro: EXEC_CORE_MUL_EN.
module exec_core_alu
    import exec_core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              imm_mode,
    output logic [DATA_W-1:0] res,
    output logic [DATA_W-1:0] res_hi,
    output flags_t            flags
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
`ifdef EXEC_CORE_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    always_comb begin
        sum            = '0;
        res            = '0;
        res_hi         = '0;
        flags          = '0;
`ifdef EXEC_CORE_MUL_EN
        prod           = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif
        case (op)
            OP_MOV, OP_MOVSGPR: res = b;
            OP_ADD: begin
                sum            = {1'b0, a} + {1'b0, b};
                res            = sum[MSB:0];
                flags.carry    = sum[DATA_W];
                flags.overflow = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                sum            = {1'b0, a} - {1'b0, b};
                res            = sum[MSB:0];
                flags.carry    = sum[DATA_W];
                flags.overflow = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
            end
`ifdef EXEC_CORE_MUL_EN
            OP_MUL: begin
                res    = prod[MSB:0];
                res_hi = prod[2*DATA_W-1:DATA_W];
            end
`endif
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_NOT:  res = imm_mode ? ~b : ~a;
            default: res = '0;
        endcase
        flags.sign = res[MSB];
        flags.zero = (res == '0);
`ifdef EXEC_CORE_MUL_EN
        // MUL flags describe the whole product, not just the written low half.
        if (op == OP_MUL) begin
            flags.sign = prod[2*DATA_W-1];
            flags.zero = (prod == '0);
        end
`endif
    end

endmodule

// File: rtl/exec_core.sv
// Multi-cycle fetch/execute core: FSM, 32-entry GPR file, SGPR, flags and pc around exec_core_alu.
// Latency: FETCH_WAIT cycles in FETCH + 1 cycle in EXEC per instruction; results visible on the edge ending EXEC.
// Backpressure: en low freezes the FETCH wait counter and holds imem_addr; EXEC always completes.
// Ports: clk, rst_n (sync, active low), en, imem_addr/imem_rdata, pc, sign/zero/overflow/carry, halted, illegal,
// dbg_addr/dbg_data (async GPR read), dbg_sgpr. Macro: EXEC_CORE_MUL_EN adds multiplier, SGPR, MUL, MOVSGPR.
module exec_core
    import exec_core_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 11,
    parameter int FETCH_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic              sign,
    output logic              zero,
    output logic              overflow,
    output logic              carry,
    output logic              halted,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] dbg_sgpr
);

    localparam int CNT_W = (FETCH_WAIT > 1) ? $clog2(FETCH_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_WAIT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ir_q, ir_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] gpr_q [32];
    logic [DATA_W-1:0] gpr_d [32];
    flags_t            flags_q, flags_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] sgpr_val;

    logic [4:0]        op;
    logic [4:0]        rdst;
    logic              imm_mode;
    logic [DATA_W-1:0] rs1_val, op2_val;
    logic [DATA_W-1:0] alu_res, alu_hi;
    flags_t            alu_flags;

    assign op       = ir_q[IR_OPER_HI:IR_OPER_LO];
    assign rdst     = ir_q[IR_RDST_HI:IR_RDST_LO];
    assign imm_mode = ir_q[IR_IMM_BIT];
    assign rs1_val  = gpr_q[ir_q[IR_RSRC1_HI:IR_RSRC1_LO]];

    // MOVSGPR reuses the MOV datapath by presenting SGPR as the second operand.
    always_comb begin
        op2_val = gpr_q[ir_q[IR_RSRC2_HI:IR_RSRC2_LO]];
        if (op == OP_MOVSGPR)
            op2_val = sgpr_val;
        else if (imm_mode)
            op2_val = DATA_W'(ir_q[IR_ISRC_HI:IR_ISRC_LO]);
    end

    exec_core_alu #(.DATA_W(DATA_W)) u_alu (
        .op       (op),
        .a        (rs1_val),
        .b        (op2_val),
        .imm_mode (imm_mode),
        .res      (alu_res),
        .res_hi   (alu_hi),
        .flags    (alu_flags)
    );

`ifdef EXEC_CORE_MUL_EN
    logic [DATA_W-1:0] sgpr_q, sgpr_d;
    assign sgpr_val = sgpr_q;

    always_comb begin
        sgpr_d = sgpr_q;
        if (state_q == EXEC && op == OP_MUL)
            sgpr_d = alu_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sgpr_q <= '0;
        else        sgpr_q <= sgpr_d;
    end
`else
    logic unused_alu_hi;
    assign unused_alu_hi = ^alu_hi;
    assign sgpr_val      = '0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        gpr_d     = gpr_q;
        flags_d   = flags_q;
        halted_d  = halted_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH: begin
                if (en) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        ir_d    = imem_rdata;
                        state_d = EXEC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EXEC: begin
                state_d = FETCH;
                if (op == OP_HALT) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_q + 1'b1;
                    if (op_writes(op)) begin
                        gpr_d[rdst] = alu_res;
                        flags_d     = alu_flags;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            ir_q      <= '0;
            pc_q      <= '0;
            flags_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            flags_q   <= flags_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            gpr_q     <= gpr_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign sign      = flags_q.sign;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign dbg_data  = gpr_q[dbg_addr];
    assign dbg_sgpr  = sgpr_val;

endmodule
